// File: rtl/switch_word_loader.sv
// Switch/button front end that assembles eight hex nibbles into a 32-bit register write.
// Define SWLOAD_DEBOUNCE_EN to compile in per-button debouncing of DEBOUNCE_CYCLES cycles.
module switch_word_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_nibble,
  input  logic [4:0]  sw_reg,
  input  logic        btn_load,
  input  logic        btn_clear,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic [3:0]  nib_count,
  output logic [31:0] preview
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

  logic [3:0]  r_nib_s1, r_nib_s2;
  logic [4:0]  r_reg_s1, r_reg_s2;
  logic [1:0]  r_btn_s1, r_btn_s2;   // bit 0 = load, bit 1 = clear
  logic [1:0]  w_stable;
  logic [1:0]  r_stable_d, r_evt;
  logic [31:0] w_shift;

  state_t      r_state;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [3:0]  r_nib_count;
  logic [31:0] r_preview;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_s1 <= '0;
      r_nib_s2 <= '0;
      r_reg_s1 <= '0;
      r_reg_s2 <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_nib_s1 <= sw_nibble;
      r_nib_s2 <= r_nib_s1;
      r_reg_s1 <= sw_reg;
      r_reg_s2 <= r_reg_s1;
      r_btn_s1 <= {btn_clear, btn_load};
      r_btn_s2 <= r_btn_s1;
    end
  end

`ifdef SWLOAD_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0][CW-1:0] r_db_cnt;
  logic [1:0]         r_stable;

  // Counter tracks consecutive disagreement cycles; accepts the new level on the Nth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_stable <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_stable[i] <= r_btn_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_stable = r_stable;
`else
  logic w_unused_dbc;
  assign w_unused_dbc = (DEBOUNCE_CYCLES > 0);
  assign w_stable     = r_btn_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= '0;
      r_evt      <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_evt      <= w_stable & ~r_stable_d;
    end
  end

  assign w_shift = {r_preview[27:0], r_nib_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_nib_count <= '0;
      r_preview   <= '0;
    end else begin
      case (r_state)
        S_WRITE: begin
          if (wr_ready) begin
            r_state     <= S_IDLE;
            r_wr_en     <= 1'b0;
            r_nib_count <= '0;
          end
        end
        default: begin
          if (r_evt[1]) begin
            r_preview   <= '0;
            r_nib_count <= '0;
            r_state     <= S_IDLE;
          end else if (r_evt[0]) begin
            r_preview   <= w_shift;
            r_nib_count <= r_nib_count + 4'd1;
            if (r_nib_count == 4'd7) begin
              r_wr_addr <= r_reg_s2;
              r_wr_data <= w_shift;
              r_wr_en   <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_state   <= S_COLLECT;
            end
          end
        end
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign nib_count = r_nib_count;
  assign preview   = r_preview;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_switch_word_loader.sv
// Directed/randomized bench for switch_word_loader against a press-level reference model.
module tb_switch_word_loader;

`ifdef SWLOAD_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 0;
`endif
  localparam int unsigned LAT  = 4 + DB;
  localparam int unsigned MINH = (DB > 0) ? DB : 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw_nibble;
  logic [4:0]  sw_reg;
  logic        btn_load, btn_clear, wr_ready;
  logic        wr_en, busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, preview;
  logic [3:0]  nib_count;

  switch_word_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_nibble(sw_nibble), .sw_reg(sw_reg),
    .btn_load(btn_load), .btn_clear(btn_clear), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .nib_count(nib_count), .preview(preview)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned t;
    bit          ld;
    bit          cl;
    logic [3:0]  nib;
    logic [4:0]  rg;
  } ev_t;

  ev_t         q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0, n_err = 0;
  int unsigned n_wen = 0;
  logic [4:0]  cap_addr = '0;
  logic [31:0] cap_data = '0;

  logic [31:0] m_prev = '0, m_data = '0;
  logic [4:0]  m_addr = '0;
  int unsigned m_cnt = 0;
  bit          m_write = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance the model by whole presses due now, then compare all outputs.
  task automatic step();
    bit          was, ld, cl;
    logic [3:0]  nib;
    logic [4:0]  rg;
    ev_t         keep[$];
    @(negedge clk);
    cyc++;
    was = m_write;
    if (was && wr_ready) begin
      m_write = 1'b0;
      m_cnt   = 0;
    end
    ld = 1'b0; cl = 1'b0; nib = '0; rg = '0;
    foreach (q[i]) begin
      if (q[i].t == cyc) begin
        ld  = ld | q[i].ld;
        cl  = cl | q[i].cl;
        nib = q[i].nib;
        rg  = q[i].rg;
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
    if (!was && rst_n) begin
      if (cl) begin
        m_prev = '0;
        m_cnt  = 0;
      end else if (ld) begin
        m_prev = (m_prev << 4) | 32'(nib);
        m_cnt++;
        if (m_cnt == 8) begin
          m_write = 1'b1;
          m_data  = m_prev;
          m_addr  = rg;
        end
      end
    end
    if (wr_en === 1'b1) begin
      n_wen++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    chk("preview", preview, m_prev);
    chk("nib_count", 32'(nib_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_write || (m_cnt != 0)));
    chk("wr_en", 32'(wr_en), 32'(m_write));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
  endtask

  task automatic press(input bit ld, input bit cl, input logic [3:0] nib,
                       input logic [4:0] rg, input int unsigned hold);
    ev_t e;
    sw_nibble = nib;
    sw_reg    = rg;
    btn_load  = ld;
    btn_clear = cl;
    if (hold >= MINH) begin
      e.t = cyc + LAT; e.ld = ld; e.cl = cl; e.nib = nib; e.rg = rg;
      q.push_back(e);
    end
    repeat (hold) step();
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (LAT + 4) step();
  endtask

  task automatic model_reset();
    m_prev = '0; m_data = '0; m_addr = '0; m_cnt = 0; m_write = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [3:0] nb;
    rst_n = 1'b0; sw_nibble = '0; sw_reg = '0;
    btn_load = 1'b0; btn_clear = 1'b0; wr_ready = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Known word 0x12345678 to register 3 with an always-ready CPU.
    wr_ready = 1'b1;
    n_wen = 0;
    for (int k = 1; k <= 8; k++) press(1'b1, 1'b0, 4'(k), 5'd3, DB + 2);
    chk("wen_pulse_len", 32'(n_wen), 32'd1);
    chk("cap_addr", 32'(cap_addr), 32'd3);
    chk("cap_data", cap_data, 32'h12345678);
    chk("preview_kept", preview, 32'h12345678);

    // Random words, random hold lengths, wr_ready toggling outside WRITE.
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        wr_ready = 1'($urandom_range(0, 1));
        if (k == 7) wr_ready = 1'b1;
        press(1'b1, 1'b0, 4'($urandom), 5'($urandom), MINH + $urandom_range(0, 5));
      end
    end

    // Stalled write: wr_en held, extra load discarded, then accepted.
    wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) press(1'b1, 1'b0, 4'($urandom), 5'($urandom), DB + 2);
    press(1'b1, 1'b0, 4'($urandom), 5'($urandom), DB + 2);
    press(1'b0, 1'b1, 4'd0, 5'd0, DB + 2);
    chk("stall_wen", 32'(wr_en), 32'd1);
    wr_ready = 1'b1;
    repeat (3) step();

    // Glitch shorter than the debounce window, then a long hold.
    nb = 4'($urandom);
    press(1'b1, 1'b0, nb, 5'd1, 3);
    press(1'b1, 1'b0, 4'($urandom), 5'd1, 20);

    // Three nibbles, then load and clear together: clear wins.
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 4'($urandom), 5'($urandom), DB + 2);
    press(1'b1, 1'b1, 4'hf, 5'd7, DB + 2);
    chk("clr_preview", preview, 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a stalled write.
    wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) press(1'b1, 1'b0, 4'($urandom), 5'($urandom), DB + 2);
    chk("pre_rst_wen", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wen", 32'(wr_en), 32'd0);
    chk("async_preview", preview, 32'd0);
    chk("async_count", 32'(nib_count), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    sw_nibble = 4'ha;
    sw_reg    = 5'd9;
    btn_load  = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    begin
      ev_t e;
      e.t = cyc + LAT; e.ld = 1'b1; e.cl = 1'b0; e.nib = 4'ha; e.rg = 5'd9;
      q.push_back(e);
    end
    repeat (20) step();
    btn_load = 1'b0;
    repeat (LAT + 4) step();
    chk("held_through_reset", preview, 32'h0000000a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
